// File: rtl/multicycle_ctrl.sv
// ============================================================================
// multicycle_ctrl
// ----------------------------------------------------------------------------
// Multi-cycle control unit for the MIPS datapath. A registered FSM sequences
// each instruction through FETCH, DECODE, EXEC, MEM, WB, BRANCH and JUMP and
// drives the datapath mux selects, ALU class and the register-file, memory,
// IR and PC enables. Memory accesses in FETCH and MEM stall until
// mem_ready_i is high.
//
// Build option:
//   ILLEGAL_TRAP_EN  when defined, an unknown opcode in DECODE parks the FSM
//                    in TRAP (state_o = 7) until rst_i. When undefined, an
//                    unknown opcode retires as a 2-cycle NOP and TRAP is
//                    unreachable.
//
// Parameters:
//   OP_W      opcode width
//   ALU_OP_W  ALU_op_o width (>= 3, upper bits driven 0)
//   ST_W      state_o width
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   instr_op_i   opcode from the instruction register, sampled in DECODE
//   mem_ready_i  memory access completes this cycle
//   RegWrite_o   register file write enable
//   ALU_op_o     ALU control class (add / sub / funct / slt)
//   ALUSrc_o     ALU B operand is the sign-extended immediate
//   RegDst_o     destination register is rd (1) or rt (0)
//   Branch_o     branch compare cycle
//   Jump_o       jump target select
//   MemRead_o    memory read request
//   MemWrite_o   memory write request
//   MemtoReg_o   writeback data comes from memory
//   IRWrite_o    instruction register load
//   PCWrite_o    PC update (PC+4 in FETCH, jump target in JUMP)
//   state_o      current state, for debug
//   retire_o     one-cycle pulse in the last cycle of each instruction
// ============================================================================
module multicycle_ctrl #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int ST_W     = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OP_W-1:0]     instr_op_i,
    input  logic                mem_ready_i,
    output logic                RegWrite_o,
    output logic [ALU_OP_W-1:0] ALU_op_o,
    output logic                ALUSrc_o,
    output logic                RegDst_o,
    output logic                Branch_o,
    output logic                Jump_o,
    output logic                MemRead_o,
    output logic                MemWrite_o,
    output logic                MemtoReg_o,
    output logic                IRWrite_o,
    output logic                PCWrite_o,
    output logic [ST_W-1:0]     state_o,
    output logic                retire_o
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3'b011);

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = ST_W'(0),
        S_DECODE = ST_W'(1),
        S_EXEC   = ST_W'(2),
        S_MEM    = ST_W'(3),
        S_WB     = ST_W'(4),
        S_BRANCH = ST_W'(5),
        S_JUMP   = ST_W'(6),
        S_TRAP   = ST_W'(7)
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_d;

    // Instructions that go through the EXEC state: ALU ops and memory ops.
    function automatic logic is_exec_op(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI) ||
               (op == OP_LW)    || (op == OP_SW);
    endfunction

    // Any opcode this controller knows how to sequence.
    function automatic logic is_known_op(input logic [OP_W-1:0] op);
        return is_exec_op(op) || (op == OP_BEQ) || (op == OP_J);
    endfunction

    // Instructions whose second ALU operand is the sign-extended immediate.
    function automatic logic uses_imm(input logic [OP_W-1:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_LW) || (op == OP_SW);
    endfunction

    // ALU class for the EXEC / MEM address computation.
    function automatic logic [ALU_OP_W-1:0] alu_class(input logic [OP_W-1:0] op);
        logic [ALU_OP_W-1:0] cls;
        cls = ALU_ADD;
        if (op == OP_RTYPE) begin
            cls = ALU_FUNCT;
        end else if (op == OP_SLTI) begin
            cls = ALU_SLT;
        end else if (op == OP_BEQ) begin
            cls = ALU_SUB;
        end
        return cls;
    endfunction

    // State and latched opcode. Reset always returns to FETCH and clears the
    // opcode, abandoning whatever instruction was in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic. The opcode is captured only in DECODE; every other
    // state works from the latched copy so the IR may change underneath.
    // mem_ready_i only matters in FETCH and MEM, where it ends a stall.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = instr_op_i;
                if (is_exec_op(instr_op_i)) begin
                    state_d = S_EXEC;
                end else if (instr_op_i == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (instr_op_i == OP_J) begin
                    state_d = S_JUMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                if ((op_q == OP_LW) || (op_q == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready_i) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                state_d = S_FETCH;
            end
            S_JUMP: begin
                state_d = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = S_TRAP;
`else
                state_d = S_FETCH;
`endif
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Output decode from the registered state and opcode. The exceptions are
    // the handshake-dependent enables: IR/PC load in FETCH and the sw retire
    // in MEM follow mem_ready_i, and a NOP-retired unknown opcode is
    // recognised from the live IR opcode in DECODE.
    always_comb begin
        RegWrite_o = 1'b0;
        ALU_op_o   = ALU_ADD;
        ALUSrc_o   = 1'b0;
        RegDst_o   = 1'b0;
        Branch_o   = 1'b0;
        Jump_o     = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        IRWrite_o  = 1'b0;
        PCWrite_o  = 1'b0;
        retire_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                retire_o = ~is_known_op(instr_op_i);
`endif
            end
            S_EXEC: begin
                ALU_op_o = alu_class(op_q);
                ALUSrc_o = uses_imm(op_q);
            end
            S_MEM: begin
                ALU_op_o   = alu_class(op_q);
                ALUSrc_o   = 1'b1;
                MemRead_o  = (op_q == OP_LW);
                MemWrite_o = (op_q == OP_SW);
                retire_o   = (op_q == OP_SW) && mem_ready_i;
            end
            S_WB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = (op_q == OP_RTYPE);
                MemtoReg_o = (op_q == OP_LW);
                retire_o   = 1'b1;
            end
            S_BRANCH: begin
                Branch_o = 1'b1;
                ALU_op_o = ALU_SUB;
                retire_o = 1'b1;
            end
            S_JUMP: begin
                Jump_o    = 1'b1;
                PCWrite_o = 1'b1;
                retire_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// tb_multicycle_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for multicycle_ctrl. Each instruction is expanded into
// a list of per-cycle records (phase, opcode, ready) from the instruction's
// class and its chosen fetch/memory wait counts; a single compare process
// checks state and every output against that list each cycle. Directed
// instructions pin the latencies with literal values, then a randomized run
// mixes opcodes, wait states and mid-instruction resets.
// ============================================================================
module tb_multicycle_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] instr_op_i = 6'd0;
    logic       mem_ready_i = 1'b0;
    logic       RegWrite_o;
    logic [2:0] ALU_op_o;
    logic       ALUSrc_o;
    logic       RegDst_o;
    logic       Branch_o;
    logic       Jump_o;
    logic       MemRead_o;
    logic       MemWrite_o;
    logic       MemtoReg_o;
    logic       IRWrite_o;
    logic       PCWrite_o;
    logic [2:0] state_o;
    logic       retire_o;

    multicycle_ctrl #(.OP_W(6), .ALU_OP_W(3), .ST_W(3)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .instr_op_i  (instr_op_i),
        .mem_ready_i (mem_ready_i),
        .RegWrite_o  (RegWrite_o),
        .ALU_op_o    (ALU_op_o),
        .ALUSrc_o    (ALUSrc_o),
        .RegDst_o    (RegDst_o),
        .Branch_o    (Branch_o),
        .Jump_o      (Jump_o),
        .MemRead_o   (MemRead_o),
        .MemWrite_o  (MemWrite_o),
        .MemtoReg_o  (MemtoReg_o),
        .IRWrite_o   (IRWrite_o),
        .PCWrite_o   (PCWrite_o),
        .state_o     (state_o),
        .retire_o    (retire_o)
    );

    // 100 MHz-style free-running clock.
    always #5 clk_i = ~clk_i;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_DECODE = 3'd1;
    localparam logic [2:0] PH_EXEC   = 3'd2;
    localparam logic [2:0] PH_MEM    = 3'd3;
    localparam logic [2:0] PH_WB     = 3'd4;
    localparam logic [2:0] PH_BRANCH = 3'd5;
    localparam logic [2:0] PH_JUMP   = 3'd6;
    localparam logic [2:0] PH_TRAP   = 3'd7;

    typedef struct packed {
        logic [2:0] st;
        logic       rdy;
        logic [5:0] op;
    } CycleRec;

    CycleRec plan[$];
    CycleRec curExp;
    bit      expValid = 1'b0;

    int assertCount = 0;
    int failCount   = 0;
    int cycCount    = 0;
    int lastLatency = -1;
    int retireSeen  = 0;

    // Records one comparison and reports it when it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic bit isKnown(input logic [5:0] op);
        return op inside {OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J};
    endfunction

    function automatic logic [2:0] aluClass(input logic [5:0] op);
        case (op)
            OP_R:    return 3'b010;
            OP_SLTI: return 3'b011;
            OP_BEQ:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs for one cycle, packed as
    // {RegWrite, ALU_op, ALUSrc, RegDst, Branch, Jump, MemRead, MemWrite,
    //  MemtoReg, IRWrite, PCWrite, retire}.
    function automatic logic [13:0] expOut(input CycleRec r);
        logic       rw, src, dst, br, jmp, mr, mw, m2r, irw, pcw, ret;
        logic [2:0] alu;
        {rw, src, dst, br, jmp, mr, mw, m2r, irw, pcw, ret} = '0;
        alu = 3'b000;
        case (r.st)
            PH_FETCH: begin
                mr  = 1'b1;
                irw = r.rdy;
                pcw = r.rdy;
            end
            PH_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                ret = !isKnown(r.op);
`endif
            end
            PH_EXEC: begin
                alu = aluClass(r.op);
                src = r.op inside {OP_ADDI, OP_SLTI, OP_LW, OP_SW};
            end
            PH_MEM: begin
                src = 1'b1;
                mr  = (r.op == OP_LW);
                mw  = (r.op == OP_SW);
                ret = (r.op == OP_SW) && r.rdy;
            end
            PH_WB: begin
                rw  = 1'b1;
                dst = (r.op == OP_R);
                m2r = (r.op == OP_LW);
                ret = 1'b1;
            end
            PH_BRANCH: begin
                br  = 1'b1;
                alu = 3'b001;
                ret = 1'b1;
            end
            PH_JUMP: begin
                jmp = 1'b1;
                pcw = 1'b1;
                ret = 1'b1;
            end
            default: begin
            end
        endcase
        return {rw, alu, src, dst, br, jmp, mr, mw, m2r, irw, pcw, ret};
    endfunction

    function automatic CycleRec mk(input logic [2:0] st, input logic rdy,
                                   input logic [5:0] op);
        CycleRec r;
        r.st  = st;
        r.rdy = rdy;
        r.op  = op;
        return r;
    endfunction

    // Expands one instruction into its cycle-by-cycle phase list. Phases
    // where mem_ready_i is ignored get a random ready value.
    task automatic buildPlan(input logic [5:0] op, input int fw, input int mw);
        plan.delete();
        for (int i = 0; i < fw; i++) plan.push_back(mk(PH_FETCH, 1'b0, op));
        plan.push_back(mk(PH_FETCH, 1'b1, op));
        plan.push_back(mk(PH_DECODE, 1'($urandom), op));
        if (op inside {OP_R, OP_ADDI, OP_SLTI}) begin
            plan.push_back(mk(PH_EXEC, 1'($urandom), op));
            plan.push_back(mk(PH_WB, 1'($urandom), op));
        end else if (op inside {OP_LW, OP_SW}) begin
            plan.push_back(mk(PH_EXEC, 1'($urandom), op));
            for (int i = 0; i < mw; i++) plan.push_back(mk(PH_MEM, 1'b0, op));
            plan.push_back(mk(PH_MEM, 1'b1, op));
            if (op == OP_LW) plan.push_back(mk(PH_WB, 1'($urandom), op));
        end else if (op == OP_BEQ) begin
            plan.push_back(mk(PH_BRANCH, 1'($urandom), op));
        end else if (op == OP_J) begin
            plan.push_back(mk(PH_JUMP, 1'($urandom), op));
        end else begin
`ifdef ILLEGAL_TRAP_EN
            for (int i = 0; i < 5; i++) plan.push_back(mk(PH_TRAP, 1'($urandom), op));
`endif
        end
    endtask

    // Drives up to maxCycles records of the current plan, one per clock.
    // The IR opcode carries the real opcode only in DECODE and is random
    // elsewhere, since the controller must ignore it then.
    task automatic applyStimulus(input int maxCycles);
        for (int i = 0; i < plan.size() && i < maxCycles; i++) begin
            mem_ready_i = plan[i].rdy;
            instr_op_i  = (plan[i].st == PH_DECODE) ? plan[i].op : 6'($urandom);
            curExp      = plan[i];
            expValid    = 1'b1;
            @(posedge clk_i);
            #1;
        end
    endtask

    // Two reset cycles with memory not ready; the second is checked as a
    // stalled FETCH, plus literal pins on the reset state.
    task automatic applyReset();
        rst_i       = 1'b1;
        mem_ready_i = 1'b0;
        expValid    = 1'b0;
        @(posedge clk_i);
        #1;
        curExp   = mk(PH_FETCH, 1'b0, 6'd0);
        expValid = 1'b1;
        #3;
        checkOutput("rstState", 32'(state_o), 32'd0);
        checkOutput("rstMemRead", 32'(MemRead_o), 32'd1);
        checkOutput("rstIRWrite", 32'(IRWrite_o), 32'd0);
        checkOutput("rstPCWrite", 32'(PCWrite_o), 32'd0);
        checkOutput("rstRetire", 32'(retire_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i    = 1'b0;
        cycCount = 0;
    endtask

    // Compare process: every cycle with a valid expectation, state and all
    // outputs are checked against the plan; retire spacing is measured from
    // the DUT for the latency pins.
    always @(negedge clk_i) begin
        if (expValid) begin
            checkOutput("state", 32'(state_o), 32'(curExp.st));
            checkOutput("outputs",
                        32'({RegWrite_o, ALU_op_o, ALUSrc_o, RegDst_o, Branch_o,
                             Jump_o, MemRead_o, MemWrite_o, MemtoReg_o,
                             IRWrite_o, PCWrite_o, retire_o}),
                        32'(expOut(curExp)));
            if (!rst_i) begin
                cycCount++;
                if (retire_o) begin
                    lastLatency = cycCount;
                    cycCount    = 0;
                    retireSeen++;
                end
            end
        end
    end

    task automatic runDirected(input string name, input logic [5:0] op,
                               input int fw, input int mw, input int latency);
        lastLatency = -1;
        buildPlan(op, fw, mw);
        applyStimulus(plan.size());
        checkOutput(name, 32'(lastLatency), 32'(latency));
    endtask

    initial begin
        int         retireBefore;
        logic [5:0] opTable[7];
        logic [5:0] op;
        int         maxCycles;

        opTable = '{OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J};

        applyReset();

        retireBefore = retireSeen;
        runDirected("latRtype1", OP_R, 0, 0, 4);
        runDirected("latRtype2", OP_R, 0, 0, 4);
        checkOutput("rtypeRetires", 32'(retireSeen - retireBefore), 32'd2);
        runDirected("latLwStall", OP_LW, 0, 3, 8);
        runDirected("latLwFetchWait", OP_LW, 2, 0, 7);
        runDirected("latSw", OP_SW, 0, 0, 4);
        runDirected("latAddi", OP_ADDI, 0, 0, 4);
        runDirected("latSlti", OP_SLTI, 0, 0, 4);
        runDirected("latBeq", OP_BEQ, 0, 0, 3);
        runDirected("latJ", OP_J, 0, 0, 3);

`ifdef ILLEGAL_TRAP_EN
        retireBefore = retireSeen;
        buildPlan(6'b111111, 0, 0);
        applyStimulus(plan.size());
        checkOutput("trapState", 32'(state_o), 32'd7);
        checkOutput("trapNoRetire", 32'(retireSeen - retireBefore), 32'd0);
        applyReset();
`else
        runDirected("latIllegal", 6'b111111, 0, 0, 2);
`endif

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 7) op = 6'($urandom);
            else op = opTable[$urandom_range(0, 6)];
            buildPlan(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            maxCycles = ($urandom_range(0, 11) == 0) ?
                        int'($urandom_range(1, plan.size())) : plan.size();
            applyStimulus(maxCycles);
            if (maxCycles < plan.size()) begin
                applyReset();
            end else begin
`ifdef ILLEGAL_TRAP_EN
                if (!isKnown(op)) applyReset();
`endif
            end
        end

        expValid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
